// File: rtl/vga_sync_pkg.sv
// vga_pkg: default 640x480@60 timing and the sync-window constants derived
// from it, shared by the raster generator, its interface and its consumers.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int CLK_DIV   = 2;

  localparam int H_ACTIVE  = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;

  localparam int V_ACTIVE  = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int TICK_LINE = 481;

endpackage

// File: rtl/vga_sync_if.sv
// vga_sync_if: raster outputs of vga_sync bundled for the renderers and the
// DAC path.
//   master: driven by vga_sync (x, y, hsync, vsync, video_on, pix_tick,
//           refr_tick)
//   slave : consumers of the raster timing
interface vga_sync_if;
  import vga_pkg::*;

  coord_t x;
  coord_t y;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   pix_tick;
  logic   refr_tick;

  modport master (output x, y, hsync, vsync, video_on, pix_tick, refr_tick);
  modport slave  (input  x, y, hsync, vsync, video_on, pix_tick, refr_tick);

endinterface

// File: rtl/vga_sync_pixel_tick_gen.sv
// pixel_tick_gen: divides the board clock down to the pixel rate.
//   clk      in  board clock
//   reset    in  asynchronous active-low reset
//   pix_en   out combinational advance enable (div == CLK_DIV-1)
//   pix_tick out registered copy of the same strobe, forced low in reset
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en,
  output logic pix_tick
);
  import vga_pkg::*;

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic [DW-1:0] div_nxt;

  always_comb begin
    div_nxt = (div == DIV_LAST) ? '0 : div + DW'(1);
  end

  // The counters advance on the combinational enable so that CLK_DIV=1
  // moves on the very first edge after reset; the exported strobe is
  // registered from the next divider value so it still reads 0 in reset.
  assign pix_en = (div == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div      <= '0;
      pix_tick <= 1'b0;
    end else begin
      div      <= div_nxt;
      pix_tick <= (div_nxt == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_sync.sv
// vga_sync: raster timing generator (x/y counters, sync decode, frame tick).
//   clk   in  board clock
//   reset in  asynchronous active-low reset
//   vga   master modport of vga_sync_if carrying x, y, hsync, vsync,
//         video_on, pix_tick and refr_tick
module vga_sync #(
  parameter int CLK_DIV   = vga_pkg::CLK_DIV,
  parameter int H_ACTIVE  = vga_pkg::H_ACTIVE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_ACTIVE  = vga_pkg::V_ACTIVE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP,
  parameter int TICK_LINE = vga_pkg::TICK_LINE
) (
  input  logic      clk,
  input  logic      reset,
  vga_sync_if.master vga
);
  import vga_pkg::*;

  localparam coord_t X_LAST   = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t Y_LAST   = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam coord_t X_ACT    = coord_t'(H_ACTIVE);
  localparam coord_t Y_ACT    = coord_t'(V_ACTIVE);
  localparam coord_t TICK_Y   = coord_t'(TICK_LINE);

  logic   pix_en;
  logic   pix_tick;
  coord_t x_q, y_q;
  coord_t x_nxt, y_nxt;
  logic   hsync_q, vsync_q, video_on_q, refr_q;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .pix_en   (pix_en),
    .pix_tick (pix_tick)
  );

  always_comb begin
    x_nxt = x_q;
    y_nxt = y_q;
    if (pix_en) begin
      if (x_q == X_LAST) begin
        x_nxt = '0;
        y_nxt = (y_q == Y_LAST) ? '0 : y_q + coord_t'(1);
      end else begin
        x_nxt = x_q + coord_t'(1);
      end
    end
  end

  // Counter/decode register stage: decode is taken from the next-state
  // counters so the sync and blanking flags land with the x/y they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q        <= '0;
      y_q        <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
      refr_q     <= 1'b0;
    end else begin
      x_q        <= x_nxt;
      y_q        <= y_nxt;
      hsync_q    <= !((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST));
      vsync_q    <= !((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST));
      video_on_q <= (x_nxt < X_ACT) && (y_nxt < Y_ACT);
      // Only the advancing edge may fire, so the tick does not repeat for
      // the rest of the clocks spent on pixel (0, TICK_LINE).
      refr_q     <= pix_en && (x_nxt == '0) && (y_nxt == TICK_Y);
    end
  end

  assign vga.x         = x_q;
  assign vga.y         = y_q;
  assign vga.hsync     = hsync_q;
  assign vga.vsync     = vsync_q;
  assign vga.video_on  = video_on_q;
  assign vga.pix_tick  = pix_tick;
  assign vga.refr_tick = refr_q;

endmodule

// File: tb/tb_vga_sync.sv
module tb_vga_sync;

  typedef struct packed {
    int d; int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb; int tl;
  } tim_t;

  typedef struct packed {
    logic [9:0] x; logic [9:0] y;
    logic hs; logic vs; logic von; logic pt; logic rt;
  } exp_t;

  localparam tim_t T_DEF = '{d:2, ha:640, hf:16, hs:96, hb:48,
                             va:480, vf:10, vs:2, vb:33, tl:481};
  localparam tim_t T_SML = '{d:3, ha:8, hf:2, hs:3, hb:2,
                             va:6, vf:1, vs:2, vb:1, tl:7};
  localparam tim_t T_ONE = '{d:1, ha:640, hf:16, hs:96, hb:48,
                             va:480, vf:10, vs:2, vb:33, tl:481};

  logic clk;
  logic reset;
  int   n;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_sync_if if_def();
  vga_sync_if if_sml();
  vga_sync_if if_one();

  vga_sync u_def (.clk(clk), .reset(reset), .vga(if_def));

  vga_sync #(.CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
             .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .TICK_LINE(7))
    u_sml (.clk(clk), .reset(reset), .vga(if_sml));

  vga_sync #(.CLK_DIV(1)) u_one (.clk(clk), .reset(reset), .vga(if_one));

  // Reference: position is the count of pixel periods elapsed since reset
  // release, folded into the frame; everything else follows from it.
  function automatic exp_t model(input int k, input tim_t t);
    exp_t e;
    int ht, vt, p, px, py;
    ht = t.ha + t.hf + t.hs + t.hb;
    vt = t.va + t.vf + t.vs + t.vb;
    p  = (k / t.d) % (ht * vt);
    px = p % ht;
    py = p / ht;
    e.x   = 10'(px);
    e.y   = 10'(py);
    e.hs  = !(px >= t.ha + t.hf && px < t.ha + t.hf + t.hs);
    e.vs  = !(py >= t.va + t.vf && py < t.va + t.vf + t.vs);
    e.von = (px < t.ha) && (py < t.va);
    e.pt  = (k % t.d) == (t.d - 1);
    e.rt  = (k > 0) && (k % t.d == 0) && (px == 0) && (py == t.tl);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    n = n + 1;
    @(negedge clk);
  endtask

  task automatic restart(input int hold);
    @(negedge clk);
    reset = 1'b0;
    repeat (hold) @(negedge clk);
    reset = 1'b1;
    n = 0;
  endtask

  task automatic test_reset();
    exp_t o;
    int hold;
    hold = $urandom_range(3, 7);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      o = {if_def.x, if_def.y, if_def.hsync, if_def.vsync, if_def.video_on,
           if_def.pix_tick, if_def.refr_tick};
      checks++;
      if (o !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset_def got=%h want=%h", o,
                 {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      end
      checks++;
      if ({if_one.pix_tick, if_one.refr_tick, if_sml.pix_tick,
           if_sml.hsync, if_one.x} !== {1'b0, 1'b0, 1'b0, 1'b1, 10'd0}) begin
        failures++;
        $display("FAIL reset_ticks got one_pt=%b one_rt=%b sml_pt=%b sml_hs=%b one_x=%0d want 0 0 0 1 0",
                 if_one.pix_tick, if_one.refr_tick, if_sml.pix_tick,
                 if_sml.hsync, if_one.x);
      end
    end
    reset = 1'b1;
    n = 0;
  endtask

  task automatic test_pix_tick();
    int len;
    restart($urandom_range(2, 5));
    len = $urandom_range(8, 20);
    for (int i = 0; i < len; i++) begin
      step();
      checks++;
      if (if_def.pix_tick !== ((n % 2) == 1)) begin
        failures++;
        $display("FAIL pix_tick n=%0d got=%b want=%b", n, if_def.pix_tick,
                 (n % 2) == 1);
      end
      checks++;
      if (if_one.pix_tick !== 1'b1) begin
        failures++;
        $display("FAIL pix_tick_div1 n=%0d got=%b want=1", n, if_one.pix_tick);
      end
      if (n == 1) begin
        checks++;
        if ({if_def.video_on, if_def.x, if_def.y} !== {1'b1, 10'd0, 10'd0}) begin
          failures++;
          $display("FAIL first_edge got von=%b x=%0d y=%0d want von=1 x=0 y=0",
                   if_def.video_on, if_def.x, if_def.y);
        end
      end
    end
  endtask

  task automatic test_line();
    exp_t e, o;
    int hs_low, hs_fall_x, von_fall_x, wraps;
    logic [9:0] px, py;
    logic pvon, phs;
    hs_low = 0; hs_fall_x = -1; von_fall_x = -1; wraps = 0;
    px = '0; py = '0; pvon = 1'b0; phs = 1'b1;
    restart($urandom_range(2, 5));
    for (int i = 0; i < 1620; i++) begin
      step();
      e = model(n, T_DEF);
      o = {if_def.x, if_def.y, if_def.hsync, if_def.vsync, if_def.video_on,
           if_def.pix_tick, if_def.refr_tick};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL line n=%0d got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b rt=%b want x=%0d y=%0d hs=%b vs=%b von=%b pt=%b rt=%b",
                 n, o.x, o.y, o.hs, o.vs, o.von, o.pt, o.rt,
                 e.x, e.y, e.hs, e.vs, e.von, e.pt, e.rt);
      end
      if (o.y == 10'd0 && !o.hs) hs_low++;
      if (phs && !o.hs && hs_fall_x < 0) hs_fall_x = int'(o.x);
      if (pvon && !o.von && von_fall_x < 0) von_fall_x = int'(o.x);
      if (px == 10'd799 && o.x == 10'd0) begin
        wraps++;
        checks++;
        if (o.y !== py + 10'd1) begin
          failures++;
          $display("FAIL line_wrap got y=%0d want y=%0d", o.y, py + 10'd1);
        end
      end
      px = o.x; py = o.y; pvon = o.von; phs = o.hs;
    end
    checks++;
    if (hs_low != 192) begin
      failures++;
      $display("FAIL hsync_width got=%0d want=192", hs_low);
    end
    checks++;
    if (hs_fall_x != 656) begin
      failures++;
      $display("FAIL hsync_start got=%0d want=656", hs_fall_x);
    end
    checks++;
    if (von_fall_x != 640) begin
      failures++;
      $display("FAIL video_off_x got=%0d want=640", von_fall_x);
    end
    checks++;
    if (wraps != 1) begin
      failures++;
      $display("FAIL line_wraps got=%0d want=1", wraps);
    end
  endtask

  task automatic test_frame();
    exp_t e, o;
    int refr_cnt, vs_low;
    int refr_n [2];
    logic [9:0] px, py;
    refr_cnt = 0; vs_low = 0;
    refr_n[0] = -1; refr_n[1] = -1;
    px = '0; py = '0;
    restart($urandom_range(2, 5));
    for (int i = 0; i < 1000; i++) begin
      step();
      e = model(n, T_SML);
      o = {if_sml.x, if_sml.y, if_sml.hsync, if_sml.vsync, if_sml.video_on,
           if_sml.pix_tick, if_sml.refr_tick};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL frame n=%0d got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b rt=%b want x=%0d y=%0d hs=%b vs=%b von=%b pt=%b rt=%b",
                 n, o.x, o.y, o.hs, o.vs, o.von, o.pt, o.rt,
                 e.x, e.y, e.hs, e.vs, e.von, e.pt, e.rt);
      end
      if (n <= 450 && !o.vs) vs_low++;
      if (o.rt) begin
        if (refr_cnt < 2) refr_n[refr_cnt] = n;
        refr_cnt++;
        checks++;
        if ({o.x, o.y} !== {10'd0, 10'd7}) begin
          failures++;
          $display("FAIL refr_pos got x=%0d y=%0d want x=0 y=7", o.x, o.y);
        end
      end
      if (py == 10'd9 && o.y == 10'd0) begin
        checks++;
        if (o.x !== 10'd0 || px !== 10'd14) begin
          failures++;
          $display("FAIL frame_wrap got x=%0d prev_x=%0d want x=0 prev_x=14",
                   o.x, px);
        end
      end
      px = o.x; py = o.y;
    end
    checks++;
    if (refr_cnt != 2) begin
      failures++;
      $display("FAIL refr_count got=%0d want=2", refr_cnt);
    end
    checks++;
    if (refr_n[1] - refr_n[0] != 450) begin
      failures++;
      $display("FAIL refr_period got=%0d want=450", refr_n[1] - refr_n[0]);
    end
    checks++;
    if (vs_low != 90) begin
      failures++;
      $display("FAIL vsync_width got=%0d want=90", vs_low);
    end
  endtask

  task automatic test_clk_div1();
    exp_t e, o;
    logic [9:0] px;
    px = '0;
    restart($urandom_range(2, 5));
    for (int i = 0; i < 1700; i++) begin
      step();
      e = model(n, T_ONE);
      o = {if_one.x, if_one.y, if_one.hsync, if_one.vsync, if_one.video_on,
           if_one.pix_tick, if_one.refr_tick};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL div1 n=%0d got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b want x=%0d y=%0d hs=%b vs=%b von=%b pt=%b",
                 n, o.x, o.y, o.hs, o.vs, o.von, o.pt,
                 e.x, e.y, e.hs, e.vs, e.von, e.pt);
      end
      checks++;
      if (o.x !== ((px == 10'd799) ? 10'd0 : px + 10'd1)) begin
        failures++;
        $display("FAIL div1_step n=%0d got x=%0d prev=%0d", n, o.x, px);
      end
      if (n == 800) begin
        checks++;
        if ({o.x, o.y} !== {10'd0, 10'd1}) begin
          failures++;
          $display("FAIL div1_line got x=%0d y=%0d want x=0 y=1", o.x, o.y);
        end
      end
      px = o.x;
    end
  endtask

  task automatic test_async_reset();
    exp_t e, o;
    int hs_fall_x, hs_fall_y;
    logic phs;
    hs_fall_x = -1; hs_fall_y = -1; phs = 1'b1;
    restart($urandom_range(2, 5));
    repeat (1400) step();
    checks++;
    if ({if_def.x, if_def.y, if_def.hsync} !== {10'd700, 10'd0, 1'b0}) begin
      failures++;
      $display("FAIL pre_reset got x=%0d y=%0d hs=%b want x=700 y=0 hs=0",
               if_def.x, if_def.y, if_def.hsync);
    end
    #($urandom_range(1, 3));
    reset = 1'b0;
    #1;
    o = {if_def.x, if_def.y, if_def.hsync, if_def.vsync, if_def.video_on,
         if_def.pix_tick, if_def.refr_tick};
    checks++;
    if (o !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got=%h want=%h", o,
               {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    repeat ($urandom_range(1, 4)) @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 1400; i++) begin
      step();
      e = model(n, T_DEF);
      o = {if_def.x, if_def.y, if_def.hsync, if_def.vsync, if_def.video_on,
           if_def.pix_tick, if_def.refr_tick};
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL restart n=%0d got x=%0d y=%0d hs=%b von=%b pt=%b want x=%0d y=%0d hs=%b von=%b pt=%b",
                 n, o.x, o.y, o.hs, o.von, o.pt, e.x, e.y, e.hs, e.von, e.pt);
      end
      if (phs && !o.hs && hs_fall_x < 0) begin
        hs_fall_x = int'(o.x);
        hs_fall_y = int'(o.y);
      end
      phs = o.hs;
    end
    checks++;
    if (hs_fall_x != 656 || hs_fall_y != 0) begin
      failures++;
      $display("FAIL restart_hsync got x=%0d y=%0d want x=656 y=0",
               hs_fall_x, hs_fall_y);
    end
  endtask

  initial begin
    reset    = 1'b0;
    n        = 0;
    checks   = 0;
    failures = 0;
    test_reset();
    test_pix_tick();
    test_line();
    test_frame();
    test_clk_div1();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
